// File: rtl/pattern_timer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the pattern-triggered programmable timer:
//   - state_t : sequencer states (SEARCH, SHIFT, COUNT, WAIT_ACK)
//   - DEF_*   : default pattern, widths and tick rate used as parameter
//               defaults by pattern_timer_ctrl and countdown_unit
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        SEARCH   = 2'd0,
        SHIFT    = 2'd1,
        COUNT    = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    localparam int                   DEF_PAT_W           = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN         = 4'b1101;
    localparam int                   DEF_DELAY_W         = 4;
    localparam int                   DEF_TICKS_PER_COUNT = 1000;
    // A single-tick configuration still needs a 1-bit counter.
    localparam int                   DEF_TICK_W          =
        (DEF_TICKS_PER_COUNT > 1) ? $clog2(DEF_TICKS_PER_COUNT) : 1;

endpackage

// File: rtl/pattern_timer_ctrl_countdown.sv
// ---------------------------------------------------------------------------
// countdown_unit
// Delay register plus tick prescaler for the programmable timer.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   shift        : shift shift_bit into the delay register (LSB side)
//   shift_bit    : serial delay bit
//   tick_load    : load the tick counter with TICKS_PER_COUNT-1
//   step         : advance the countdown by one clock cycle
//   delay        : current delay register (remaining delay units)
//   zero         : tick counter and delay register both zero
// ---------------------------------------------------------------------------
module countdown_unit
    import timer_pkg::*;
#(
    parameter int DELAY_W         = DEF_DELAY_W,
    parameter int TICKS_PER_COUNT = DEF_TICKS_PER_COUNT,
    parameter int TICK_W          = DEF_TICK_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               shift_bit,
    input  logic               tick_load,
    input  logic               step,
    output logic [DELAY_W-1:0] delay,
    output logic               zero
);

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_COUNT - 1);

    logic [TICK_W-1:0] tick;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            delay <= '0;
            tick  <= '0;
        end else begin
            if (shift) begin
                delay <= {delay[DELAY_W-2:0], shift_bit};
            end
            if (tick_load) begin
                tick <= TICK_MAX;
            end else if (step) begin
                // Each delay unit lasts TICKS_PER_COUNT cycles: the unit ends
                // on the cycle the tick counter is seen at zero. Neither
                // counter is ever decremented from zero.
                if (tick != '0) begin
                    tick <= tick - TICK_W'(1);
                end else if (delay != '0) begin
                    delay <= delay - DELAY_W'(1);
                    tick  <= TICK_MAX;
                end
            end
        end
    end

    assign zero = (tick == '0) && (delay == '0);

endmodule

// File: rtl/pattern_timer_ctrl.sv
// ---------------------------------------------------------------------------
// pattern_timer_ctrl
// Sequencer for the pattern-triggered programmable timer. Searches the serial
// stream for PATTERN, shifts in a DELAY_W-bit delay MSB-first, counts down
// (delay+1)*TICKS_PER_COUNT cycles, then holds done until ack.
// Ports:
//   clk       : system clock, all state changes on the rising edge
//   reset     : synchronous active-high reset
//   data      : serial input, sampled every cycle
//   ack       : acknowledge of done (only honoured while done is high)
//   shift_ena : high while the delay field is being shifted in
//   counting  : high during the countdown
//   done      : high after the countdown until ack
//   count     : remaining delay units while counting, otherwise 0
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module pattern_timer_ctrl
    import timer_pkg::*;
#(
    parameter int               PAT_W           = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN         = DEF_PATTERN,
    parameter int               DELAY_W         = DEF_DELAY_W,
    parameter int               TICKS_PER_COUNT = DEF_TICKS_PER_COUNT,
    parameter int               TICK_W          =
        (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               data,
    input  logic               ack,
    output logic               shift_ena,
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);

    localparam int HIST_W = PAT_W - 1;
    localparam int WIN_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;

    state_t             state;
    // Only the newest PAT_W-1 bits are ever compared (the current data bit
    // completes the window), so the oldest history bit is not stored.
    logic [HIST_W-1:0]  hist;
    logic [WIN_W-1:0]   win;
    logic               match;
    logic               last_sample;
    logic               tick_load;
    logic               cnt_zero;
    logic [DELAY_W-1:0] delay;

    assign match       = ({hist, data} == PATTERN);
    assign last_sample = (win == WIN_W'(DELAY_W - 1));

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        tick_load = 1'b0;
        if (state == SHIFT && last_sample) begin
            tick_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
            hist  <= '0;
            win   <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    hist <= HIST_W'({hist, data});
                    if (match) begin
                        state <= SHIFT;
                        win   <= '0;
                    end
                end
                SHIFT: begin
                    win <= win + WIN_W'(1);
                    if (last_sample) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (cnt_zero) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Bits seen before the acknowledge never contribute to
                    // the next match.
                    if (ack) begin
                        state <= SEARCH;
                        hist  <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    countdown_unit #(
        .DELAY_W         (DELAY_W),
        .TICKS_PER_COUNT (TICKS_PER_COUNT),
        .TICK_W          (TICK_W)
    ) u_countdown (
        .clk       (clk),
        .reset     (reset),
        .shift     (state == SHIFT),
        .shift_bit (data),
        .tick_load (tick_load),
        .step      (state == COUNT),
        .delay     (delay),
        .zero      (cnt_zero)
    );

    assign shift_ena = (state == SHIFT);
    assign counting  = (state == COUNT);
    assign done      = (state == WAIT_ACK);
    assign count     = counting ? delay : '0;

endmodule

// File: tb/tb_pattern_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pattern_timer_ctrl
// dut_a: default configuration (PATTERN 1101, 1000 ticks per unit).
// dut_b: PATTERN 1011, 4 ticks per unit.
// Each step drives one DUT's inputs, pushes the expected outputs for the
// coming edge onto a scoreboard queue, and compares #1 after the edge.
// ---------------------------------------------------------------------------
module tb_pattern_timer_ctrl;

    typedef struct packed {
        logic       shift_ena;
        logic       counting;
        logic       done;
        logic [3:0] count;
    } obs_t;

    typedef struct packed {
        logic reset;
        logic data;
        logic ack;
        obs_t exp;
    } vec_t;

    localparam obs_t IDLE = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a = 1'b1, data_a = 1'b0, ack_a = 1'b0;
    logic       shift_a, counting_a, done_a;
    logic [3:0] count_a;
    logic       reset_b = 1'b1, data_b = 1'b0, ack_b = 1'b0;
    logic       shift_b, counting_b, done_b;
    logic [3:0] count_b;

    pattern_timer_ctrl dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .data      (data_a),
        .ack       (ack_a),
        .shift_ena (shift_a),
        .counting  (counting_a),
        .done      (done_a),
        .count     (count_a)
    );

    pattern_timer_ctrl #(
        .PATTERN         (4'b1011),
        .TICKS_PER_COUNT (4),
        .TICK_W          (2)
    ) dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .data      (data_b),
        .ack       (ack_b),
        .shift_ena (shift_b),
        .counting  (counting_b),
        .done      (done_b),
        .count     (count_b)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];

    function automatic obs_t o(input logic s, input logic c, input logic d,
                               input logic [3:0] n);
        obs_t r;
        r.shift_ena = s;
        r.counting  = c;
        r.done      = d;
        r.count     = n;
        return r;
    endfunction

    task automatic step(input logic sel_b, input logic r, input logic d,
                        input logic a, input obs_t exp, input string name);
        obs_t act, want;
        if (sel_b) begin
            reset_b = r; data_b = d; ack_b = a;
        end else begin
            reset_a = r; data_a = d; ack_a = a;
        end
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sel_b) act = {shift_b, counting_b, done_b, count_b};
        else       act = {shift_a, counting_a, done_a, count_a};
        want = sb.pop_front();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got shift_ena=%0b counting=%0b done=%0b count=%0d, expected shift_ena=%0b counting=%0b done=%0b count=%0d",
                     name, act.shift_ena, act.counting, act.done, act.count,
                     want.shift_ena, want.counting, want.done, want.count);
        end
    endtask

    // Countdown periods first_p..last_p (period 0 is the first counting cycle).
    // The noise bits replay a start pattern to show it is not detected.
    task automatic count_run(input logic sel_b, input int dly, input int ticks,
                             input int first_p, input int last_p,
                             input logic [3:0] noise, input logic a,
                             input string tag);
        for (int p = first_p; p <= last_p; p++) begin
            step(sel_b, 1'b0, noise[3 - (p % 4)], a,
                 o(1'b0, 1'b1, 1'b0, 4'(dly - p / ticks)),
                 $sformatf("%s p=%0d", tag, p));
        end
    endtask

    vec_t tbl_a[10];
    vec_t tbl_b[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset (with pattern bits and ack present: reset wins), then
        // pattern 1101 and delay 0101.
        tbl_a[0] = '{1'b1, 1'b1, 1'b1, IDLE};
        tbl_a[1] = '{1'b1, 1'b1, 1'b0, IDLE};
        tbl_a[2] = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_a[3] = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_a[4] = '{1'b0, 1'b0, 1'b0, IDLE};
        tbl_a[5] = '{1'b0, 1'b1, 1'b0, o(1, 0, 0, 0)};
        tbl_a[6] = '{1'b0, 1'b0, 1'b0, o(1, 0, 0, 0)};
        tbl_a[7] = '{1'b0, 1'b1, 1'b0, o(1, 0, 0, 0)};
        tbl_a[8] = '{1'b0, 1'b0, 1'b0, o(1, 0, 0, 0)};
        tbl_a[9] = '{1'b0, 1'b1, 1'b0, o(0, 1, 0, 5)};

        // dut_b (PATTERN 1011): 1,1,0,1,0,0 never matches, then 1,0,1,1 does;
        // the delay field is 1111.
        tbl_b[0]  = '{1'b1, 1'b0, 1'b0, IDLE};
        tbl_b[1]  = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_b[2]  = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_b[3]  = '{1'b0, 1'b0, 1'b0, IDLE};
        tbl_b[4]  = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_b[5]  = '{1'b0, 1'b0, 1'b0, IDLE};
        tbl_b[6]  = '{1'b0, 1'b0, 1'b0, IDLE};
        tbl_b[7]  = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_b[8]  = '{1'b0, 1'b0, 1'b0, IDLE};
        tbl_b[9]  = '{1'b0, 1'b1, 1'b0, IDLE};
        tbl_b[10] = '{1'b0, 1'b1, 1'b0, o(1, 0, 0, 0)};

        // ---- dut_a: basic trigger, delay 5 -> 6000 counting cycles ----
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl_a[i].reset, tbl_a[i].data, tbl_a[i].ack,
                 tbl_a[i].exp, $sformatf("tbl_a[%0d]", i));
        end
        count_run(1'b0, 5, 1000, 1, 5999, 4'b1101, 1'b0, "count5");
        step(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 1, 0), "done_rise");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(0, 0, 1, 0), "done_hold1");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(0, 0, 1, 0), "done_hold2");
        step(1'b0, 1'b0, 1'b0, 1'b1, IDLE, "ack_clears_done");
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE, "idle_after_ack");

        // ---- overlapping match 1,1,1,0,1, delay 0, ack held high ----
        step(1'b0, 1'b0, 1'b1, 1'b1, IDLE, "ovl_b1");
        step(1'b0, 1'b0, 1'b1, 1'b1, IDLE, "ovl_b2");
        step(1'b0, 1'b0, 1'b1, 1'b1, IDLE, "ovl_b3");
        step(1'b0, 1'b0, 1'b0, 1'b1, IDLE, "ovl_b4");
        step(1'b0, 1'b0, 1'b1, 1'b1, o(1, 0, 0, 0), "ovl_match");
        step(1'b0, 1'b0, 1'b0, 1'b1, o(1, 0, 0, 0), "ovl_sh1");
        step(1'b0, 1'b0, 1'b0, 1'b1, o(1, 0, 0, 0), "ovl_sh2");
        step(1'b0, 1'b0, 1'b0, 1'b1, o(1, 0, 0, 0), "ovl_sh3");
        step(1'b0, 1'b0, 1'b0, 1'b1, o(0, 1, 0, 0), "ovl_count_start");
        count_run(1'b0, 0, 1000, 1, 998, 4'b1101, 1'b1, "count0");
        step(1'b0, 1'b0, 1'b1, 1'b1, o(0, 1, 0, 0), "count0 last");
        step(1'b0, 1'b0, 1'b1, 1'b1, o(0, 0, 1, 0), "done_one_cycle");
        step(1'b0, 1'b0, 1'b0, 1'b1, IDLE, "ack_exit_immediate");
        step(1'b0, 1'b0, 1'b1, 1'b1, IDLE, "no_stale_match");
        step(1'b0, 1'b0, 1'b1, 1'b0, IDLE, "fresh_b2");
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE, "fresh_b3");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "fresh_match");

        // ---- delay 0011, reset at counting cycle 300 ----
        step(1'b0, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 0), "d3_sh1");
        step(1'b0, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 0), "d3_sh2");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "d3_sh3");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(0, 1, 0, 3), "d3_count_start");
        count_run(1'b0, 3, 1000, 1, 299, 4'b1101, 1'b0, "count3");
        step(1'b0, 1'b1, 1'b1, 1'b1, IDLE, "reset_mid_count");
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE, "bare_delay1");
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE, "bare_delay2");
        step(1'b0, 1'b0, 1'b1, 1'b0, IDLE, "bare_delay3");
        step(1'b0, 1'b0, 1'b1, 1'b0, IDLE, "bare_delay4");
        step(1'b0, 1'b0, 1'b1, 1'b0, IDLE, "resend_b1");
        step(1'b0, 1'b0, 1'b1, 1'b0, IDLE, "resend_b2");
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE, "resend_b3");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "resend_match");
        step(1'b0, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "d8_sh1");
        step(1'b0, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 0), "d8_sh2");
        step(1'b0, 1'b0, 1'b0, 1'b0, o(1, 0, 0, 0), "d8_sh3");
        step(1'b0, 1'b0, 1'b0, 1'b0, o(0, 1, 0, 8), "d8_count_start");
        step(1'b0, 1'b1, 1'b0, 1'b0, IDLE, "reset_end_a");

        // ---- dut_b: pattern 1011, 4 ticks/unit, delay 15 -> 64 cycles ----
        for (int i = 0; i < 11; i++) begin
            step(1'b1, tbl_b[i].reset, tbl_b[i].data, tbl_b[i].ack,
                 tbl_b[i].exp, $sformatf("tbl_b[%0d]", i));
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "b_sh1");
        step(1'b1, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "b_sh2");
        step(1'b1, 1'b0, 1'b1, 1'b0, o(1, 0, 0, 0), "b_sh3");
        step(1'b1, 1'b0, 1'b1, 1'b0, o(0, 1, 0, 15), "b_count_start");
        count_run(1'b1, 15, 4, 1, 63, 4'b1011, 1'b0, "count15");
        step(1'b1, 1'b0, 1'b0, 1'b0, o(0, 0, 1, 0), "b_done_rise");
        step(1'b1, 1'b0, 1'b0, 1'b1, IDLE, "b_ack");
        step(1'b1, 1'b0, 1'b0, 1'b0, IDLE, "b_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_timer_ctrl.md
Name: pattern_timer_ctrl

Overview:
- Top-level sequencer for the pattern-triggered programmable timer.
- Watches the serial `data` stream for a start pattern, then opens a DELAY_W-cycle shift window to load a delay value MSB-first.
- Counts down (delay+1)*TICKS_PER_COUNT cycles, then raises `done` until the user acknowledges.
- Owns sequencing of the shift-enable window and the countdown datapath.

Parameters:
- PATTERN, 4'b1101, start pattern, first-received bit is MSB.
- PAT_W, 4, pattern length in bits.
- DELAY_W, 4, delay field width; also the shift-window length in cycles.
- TICKS_PER_COUNT, 1000, clock cycles per delay unit; must be ≥1.
- TICK_W, 10, tick counter width; must satisfy 2^TICK_W ≥ TICKS_PER_COUNT.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  1  serial input, sampled every cycle.
- ack  in  1  user acknowledge of `done`.
- shift_ena  out  1  high while the delay field is being shifted in.
- counting  out  1  high during the countdown.
- done  out  1  high after the countdown until `ack`.
- count  out  DELAY_W  remaining delay units while `counting`=1; 0 otherwise.

Behaviour:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high on port `reset`.
- Reset: state=SEARCH, pattern history=0, delay register=0, tick counter=0. shift_ena=counting=done=0 and count=0 from the cycle after the reset edge. Reset wins over every other input. Reset mid-operation aborts the operation; a full new pattern is required.
- Outputs are Moore: decoded from registered state only, with no combinational path from `data` or `ack`.
- States:
  - SEARCH:
    - Shifts `data` into a PAT_W-bit history register.
    - When {history[PAT_W-2:0], data}==PATTERN at edge k, goes to SHIFT at edge k.
    - Detection is overlapping: stream 1,1,1,0,1 matches on the 5th bit.
  - SHIFT:
    - shift_ena=1 for exactly DELAY_W cycles (cycles k+1..k+DELAY_W).
    - Each cycle: delay <= {delay[DELAY_W-2:0], data}.
    - An internal 2-bit window counter ends the state after the DELAY_W-th sample, then moves to COUNT.
    - The tick counter loads TICKS_PER_COUNT-1.
  - COUNT:
    - counting=1; count=delay register.
    - Tick counter decrements each cycle.
    - When tick==0 and delay!=0: delay decrements and tick reloads TICKS_PER_COUNT-1.
    - When tick==0 and delay==0: go to WAIT_ACK.
    - Total COUNT duration is exactly (delay+1)*TICKS_PER_COUNT cycles. delay=0 gives TICKS_PER_COUNT cycles; delay=15 gives 16*TICKS_PER_COUNT cycles.
  - WAIT_ACK:
    - done=1.
    - ack=1 sampled at an edge moves to SEARCH and clears the pattern history. Bits after that edge start a fresh search; no bits seen before the ack count toward a match.
- Transitions between non-SEARCH states ignore `data`, except for sampling during SHIFT. Pattern occurrences during COUNT or WAIT_ACK are never detected.
- `ack` is ignored in every state except WAIT_ACK. Holding ack=1 before done rises still exits WAIT_ACK on the first WAIT_ACK cycle, so done is high for exactly 1 cycle.
- End-to-end latency: the pattern's final bit at edge k gives:
  - shift_ena cycles k+1..k+DELAY_W;
  - counting from cycle k+DELAY_W+1;
  - done from cycle k+DELAY_W+1+(d+1)*TICKS_PER_COUNT.
- Tick and delay counters never wrap below 0; they are only decremented when nonzero.

Decomposition:
- Package `timer_pkg`:
  - state enum {SEARCH, SHIFT, COUNT, WAIT_ACK};
  - default PATTERN, PAT_W, DELAY_W, TICKS_PER_COUNT constants;
  - TICK_W derived via $clog2.
- One sub-module, `countdown_unit`. It holds the delay register plus tick counter, with load/shift/decrement controls and a `zero` output.
- The FSM, pattern history and shift window stay in the top module.

Test Plan:
- Default params; reset, then data 1,1,0,1,0,1,0,1 -> shift_ena high 4 cycles after the 4th bit; counting high 6000 cycles; count steps 5,4,3,2,1,0 with 1000 cycles each; done=1 held until ack pulse, then done=0 next cycle.
- Data 1,1,1,0,1 then 0,0,0,0 -> overlapping match at bit 5; counting for exactly 1000 cycles with count=0; done asserts at cycle 1000 of count window +1.
- TICKS_PER_COUNT=4, delay 1111 -> counting for exactly 64 cycles; count decrements every 4 cycles from 15 to 0.
- Delay 0011 loaded; reset asserted at counting cycle 300 -> all outputs 0 after that edge. Then the pattern is re-sent; a bare delay field without the pattern produces no shift_ena.
- ack held high throughout COUNT and pattern 1101 fed during COUNT/WAIT_ACK -> no retrigger; done high exactly 1 cycle; SEARCH restarts with cleared history; next 1101 after the ack edge triggers normally.
- Pattern variant PATTERN=4'b1011 -> 1,1,0,1 ignored; 1,0,1,1 triggers.
